im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Boot-time writer for the instruction memory. It receives a framed byte stream, assembles big-endian 32-bit instruction words and issues single-cycle word writes to the IM write port.
- It holds the CPU (pc/ifu) in reset until the image is loaded and its checksum has been verified.
- It sits between the external byte source and the IM write side. The fetch path reads the same array through its word address.

Parameters:
ADDR_W, 10, IM word-address width; capacity is 2^ADDR_W words
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
in_data  input  8  stream byte
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader accepts a byte this cycle; a byte is transferred when in_valid and in_ready are both high
im_we  output  1  IM write enable, one-cycle pulse
im_waddr  output  ADDR_W  IM word address
im_wdata  output  32  IM write data
cpu_hold  output  1  high: keep CPU in reset
done  output  1  image loaded and checksum OK (sticky)
err  output  1  frame error (sticky)

Behaviour:
- Reset (reset=0, asynchronous):
  - State is SYNC.
  - in_ready=0, im_we=0, im_waddr=0, im_wdata=0.
  - cpu_hold=1, done=0, err=0.
  - Word counter, byte index, length register and checksum are all 0.
- in_ready:
  - Is a registered output.
  - Equals 1 in the SYNC, LEN_HI, LEN_LO, DATA and CHK states.
  - Equals 0 in the DONE and ERR states.
  - Goes to 1 on the first clock edge after reset is released.
- Frame format, all multi-byte fields big-endian: SYNC_BYTE, LEN_HI, LEN_LO, then 4*N data bytes, then CHK.
  - N = {LEN_HI, LEN_LO} is the word count.
  - CHK is the XOR of all 4*N data bytes. The length bytes are not included in CHK.
- State machine. Each transition happens on an accepted byte.
  - SYNC: a byte equal to SYNC_BYTE moves to LEN_HI. Any other byte is discarded and the state stays in SYNC.
  - LEN_HI: latch the byte as the length high byte. Next state is LEN_LO.
  - LEN_LO: latch the byte as the length low byte.
    - If N > 2^ADDR_W, go to ERR.
    - If N == 0, go to CHK.
    - Otherwise go to DATA. Word counter=0, byte index=0, checksum=0.
  - DATA:
    - Shift the byte into the assembly register (first byte becomes [31:24]).
    - XOR the byte into the checksum.
    - Byte index increments modulo 4.
    - On the 4th byte of a word, in the next cycle: im_we=1, im_waddr=word counter, im_wdata=assembled word. The word counter then increments.
    - After the 4th byte of word N-1, the next state is CHK.
  - CHK:
    - Byte equal to the checksum: go to DONE.
    - Otherwise: go to ERR.
  - DONE: done=1 and cpu_hold=0, both registered, in the cycle after the CHK byte is accepted. The state stays in DONE until reset.
  - ERR: err=1 in the cycle after the offending byte is accepted. cpu_hold stays 1 and the state stays in ERR until reset.
- Writes:
  - im_we is a one-cycle pulse per word.
  - im_waddr and im_wdata are held stable between pulses.
  - Back-to-back bytes are accepted at one per cycle with no stall; the write cycle overlaps acceptance of the next word's first byte.
- Boundary conditions:
  - N == 2^ADDR_W: all addresses 0 to 2^ADDR_W-1 are written. The word counter must be ADDR_W+1 bits wide, so it does not wrap early.
  - in_valid=0: no state change. in_valid gaps mid-word are allowed.
  - Reset mid-frame: everything returns to its reset values. Partially written IM contents are not cleared.
  - The checksum comparison uses the running XOR including the last data byte.

Test Plan:
- Load one word. Stream A5 00 01 12 34 56 78 08 -> exactly one im_we pulse with im_waddr=0 and im_wdata=32'h12345678. One cycle after the 08 byte is accepted, done=1 and cpu_hold=0; err stays 0.
- Bad checksum, same frame with a different CHK byte. Stream A5 00 01 12 34 56 78 09 -> the one im_we write still occurs. err=1, cpu_hold=1, done=0 and in_ready=0 afterwards; further bytes are ignored.
- Empty image and sync hunting. Stream 00 FF A5 00 00 00 -> the leading 00 FF are discarded. No im_we pulse, done=1.
- Oversize length with ADDR_W=10. Stream A5 04 01 -> err=1 immediately after LEN_LO is accepted, no writes.
- Full image at capacity. Stream A5 04 00, then 1024 words where word i = i, then the matching CHK -> 1024 pulses with im_waddr 0..1023 and im_wdata=i. Then done=1.
- Gaps and reset.
  - Repeat the one-word load with in_valid deasserted for random cycles mid-word -> same result as without gaps.
  - Assert reset after the second data byte -> all outputs return to reset values immediately.
  - Then send a clean frame -> loads normally.

Source files
------------

// File: rtl/im_loader.sv
// im_loader: boot-time instruction-memory writer.
// Receives a framed byte stream (SYNC, LEN_HI, LEN_LO, 4*N data bytes, CHK),
// assembles big-endian 32-bit words and issues one-cycle IM write pulses.
// The CPU is held in reset until the image is loaded and its XOR checksum matches.
module im_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Largest legal word count: the full IM capacity.
  localparam logic [16:0]     CAP_WORDS = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  // Running checksum fold: XOR of every data byte.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    chk_fold = acc ^ b;
  endfunction

  state_t          state_r;
  logic [ADDR_W:0] word_cnt_r;   // one extra bit so a full-capacity image does not wrap
  logic [1:0]      byte_idx_r;
  logic [15:0]     len_r;
  logic [7:0]      chk_r;
  logic [23:0]     asm_r;        // first three bytes of the word being assembled

  logic            accept_s;
  logic [15:0]     n_s;
  logic            oversize_s;
  logic [ADDR_W:0] word_cnt_inc_s;
  logic            last_word_s;

  assign accept_s       = in_valid & in_ready;
  assign n_s            = {len_r[15:8], in_data};
  assign oversize_s     = ({1'b0, n_s} > CAP_WORDS);
  assign word_cnt_inc_s = word_cnt_r + CNT_ONE;
  assign last_word_s    = (16'(word_cnt_inc_s) == len_r);

  // Frame-parsing state machine with all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_SYNC;
      in_ready   <= 1'b0;
      im_we      <= 1'b0;
      im_waddr   <= '0;
      im_wdata   <= 32'h0000_0000;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_cnt_r <= '0;
      byte_idx_r <= 2'd0;
      len_r      <= 16'h0000;
      chk_r      <= 8'h00;
      asm_r      <= 24'h00_0000;
    end else begin
      im_we <= 1'b0;
      case (state_r)
        ST_SYNC: begin
          in_ready <= 1'b1;
          if (accept_s && (in_data == SYNC_BYTE)) begin
            state_r <= ST_LEN_HI;
          end else begin
            state_r <= ST_SYNC;
          end
        end
        ST_LEN_HI: begin
          in_ready <= 1'b1;
          if (accept_s) begin
            len_r[15:8] <= in_data;
            state_r     <= ST_LEN_LO;
          end else begin
            state_r <= ST_LEN_HI;
          end
        end
        ST_LEN_LO: begin
          if (accept_s) begin
            len_r[7:0] <= in_data;
            word_cnt_r <= '0;
            byte_idx_r <= 2'd0;
            chk_r      <= 8'h00;
            if (oversize_s) begin
              state_r  <= ST_ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else if (n_s == 16'h0000) begin
              state_r  <= ST_CHK;
              in_ready <= 1'b1;
            end else begin
              state_r  <= ST_DATA;
              in_ready <= 1'b1;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_DATA: begin
          in_ready <= 1'b1;
          if (accept_s) begin
            asm_r      <= {asm_r[15:0], in_data};
            chk_r      <= chk_fold(chk_r, in_data);
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              im_we      <= 1'b1;
              im_waddr   <= word_cnt_r[ADDR_W-1:0];
              im_wdata   <= {asm_r, in_data};
              word_cnt_r <= word_cnt_inc_s;
              if (last_word_s) begin
                state_r <= ST_CHK;
              end else begin
                state_r <= ST_DATA;
              end
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_CHK: begin
          if (accept_s) begin
            in_ready <= 1'b0;
            if (in_data == chk_r) begin
              state_r  <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state_r <= ST_ERR;
              err     <= 1'b1;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          in_ready <= 1'b0;
          state_r  <= ST_DONE;
        end
        ST_ERR: begin
          in_ready <= 1'b0;
          state_r  <= ST_ERR;
        end
        default: begin
          in_ready <= 1'b0;
          err      <= 1'b1;
          state_r  <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: directed frames push expected IM writes,
// an independent monitor pops and compares on every im_we pulse.
`timescale 1ns/1ps
module tb_im_loader;

  localparam int ADDR_W = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  gap_en = 1'b0;

  im_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Monitor: every write pulse must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset === 1'b1 && im_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL im_write unexpected: got addr=%0d data=%h, required no write", im_waddr, im_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (im_waddr !== e.a || im_wdata !== e.d) begin
          errors++;
          $display("FAIL im_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   im_waddr, im_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.a = a[ADDR_W-1:0];
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Offer one byte and wait (bounded) until it is accepted.
  task automatic send(input logic [7:0] b);
    int n;
    int g;
    g = gap_en ? $urandom_range(0, 3) : 0;
    repeat (g) begin
      @(posedge clock); #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h never accepted, required acceptance", b);
    end else begin
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  // Present a byte for a few cycles without waiting for acceptance.
  task automatic offer(input logic [7:0] b, input int cycles);
    in_data  = b;
    in_valid = 1'b1;
    repeat (cycles) begin
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24]);
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #1 reset = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    exp_q.delete();
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic drain_check(input string name);
    repeat (3) begin
      @(posedge clock); #1;
    end
    expect_eq(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset values while reset is held.
    repeat (2) begin
      @(posedge clock); #1;
    end
    expect_eq("rst_in_ready", 32'(in_ready), 32'd0);
    expect_eq("rst_im_we",    32'(im_we),    32'd0);
    expect_eq("rst_im_waddr", 32'(im_waddr), 32'd0);
    expect_eq("rst_im_wdata", im_wdata,      32'h0);
    expect_eq("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    expect_eq("rst_done",     32'(done),     32'd0);
    expect_eq("rst_err",      32'(err),      32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    expect_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // One-word load.
    push_wr(0, 32'h12345678);
    send(8'hA5); send(8'h00); send(8'h01);
    send_word(32'h12345678);
    expect_eq("one_pre_done", 32'(done), 32'd0);
    send(8'h08);
    expect_eq("one_done",     32'(done),     32'd1);
    expect_eq("one_cpu_hold", 32'(cpu_hold), 32'd0);
    expect_eq("one_err",      32'(err),      32'd0);
    expect_eq("one_in_ready", 32'(in_ready), 32'd0);
    drain_check("one_writes_left");

    // Bad checksum.
    do_reset();
    push_wr(0, 32'h12345678);
    send(8'hA5); send(8'h00); send(8'h01);
    send_word(32'h12345678);
    send(8'h09);
    expect_eq("bad_err",      32'(err),      32'd1);
    expect_eq("bad_cpu_hold", 32'(cpu_hold), 32'd1);
    expect_eq("bad_done",     32'(done),     32'd0);
    expect_eq("bad_in_ready", 32'(in_ready), 32'd0);
    offer(8'hA5, 3);
    offer(8'h00, 2);
    expect_eq("bad_err_sticky", 32'(err), 32'd1);
    drain_check("bad_writes_left");

    // Empty image with sync hunting.
    do_reset();
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    expect_eq("empty_done",     32'(done),     32'd1);
    expect_eq("empty_cpu_hold", 32'(cpu_hold), 32'd0);
    expect_eq("empty_err",      32'(err),      32'd0);
    drain_check("empty_writes_left");

    // Oversize length (1025 words).
    do_reset();
    send(8'hA5); send(8'h04); send(8'h01);
    expect_eq("over_err",      32'(err),      32'd1);
    expect_eq("over_in_ready", 32'(in_ready), 32'd0);
    expect_eq("over_done",     32'(done),     32'd0);
    drain_check("over_writes_left");

    // Full image at capacity: word i = i; every byte value repeats an even
    // number of times across the image, so the checksum is 00.
    do_reset();
    send(8'hA5); send(8'h04); send(8'h00);
    for (int i = 0; i < 1024; i++) begin
      push_wr(i, 32'(i));
      send_word(32'(i));
    end
    expect_eq("full_pre_done", 32'(done), 32'd0);
    send(8'h00);
    expect_eq("full_done", 32'(done), 32'd1);
    expect_eq("full_err",  32'(err),  32'd0);
    drain_check("full_writes_left");

    // One-word load with random in_valid gaps.
    do_reset();
    gap_en = 1'b1;
    push_wr(0, 32'h12345678);
    send(8'hA5); send(8'h00); send(8'h01);
    send_word(32'h12345678);
    send(8'h08);
    gap_en = 1'b0;
    expect_eq("gap_done",     32'(done),     32'd1);
    expect_eq("gap_cpu_hold", 32'(cpu_hold), 32'd0);
    drain_check("gap_writes_left");

    // Reset mid-frame after the second data byte of word 1.
    do_reset();
    push_wr(0, 32'h11223344);
    send(8'hA5); send(8'h00); send(8'h02);
    send_word(32'h11223344);
    send(8'h55); send(8'h66);
    expect_eq("mid_wdata_held", im_wdata, 32'h11223344);
    reset = 1'b0;
    #1;
    expect_eq("mid_in_ready", 32'(in_ready), 32'd0);
    expect_eq("mid_im_waddr", 32'(im_waddr), 32'd0);
    expect_eq("mid_im_wdata", im_wdata,      32'h0);
    expect_eq("mid_cpu_hold", 32'(cpu_hold), 32'd1);
    expect_eq("mid_done",     32'(done),     32'd0);
    expect_eq("mid_err",      32'(err),      32'd0);
    expect_eq("mid_writes_left", 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Clean frame after the mid-frame reset: DE^AD^BE^EF = 22.
    push_wr(0, 32'hDEADBEEF);
    send(8'hA5); send(8'h00); send(8'h01);
    send_word(32'hDEADBEEF);
    send(8'h22);
    expect_eq("clean_done",     32'(done),     32'd1);
    expect_eq("clean_cpu_hold", 32'(cpu_hold), 32'd0);
    expect_eq("clean_err",      32'(err),      32'd0);
    drain_check("clean_writes_left");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
